// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline results have priority over buffered long-latency results; a pending-register scoreboard drives the decode hazard flag.
// Optional feature macro: WB_STARVE_GUARD_EN (forces a FIFO-head grant after STARVE_MAX waiting cycles).
`timescale 1ns/1ps
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic            pipe_stall,
    output logic            RegWrite,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] WriteData
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_params
        $error("wb_arbiter: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_MAX >= 1");
    end

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     pending;
    logic [31:0]     pending_next;

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            pipe_valid;
    logic            grant_pipe;
    logic            grant_ll;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    // Ready comes from the registered count only, so a pop does not reopen a full FIFO in the same cycle.
    assign fifo_empty = (count == '0);
    assign ll_ready   = rst_n && (count != FULL_COUNT);
    assign push       = ll_valid && ll_ready && (ll_rd != 5'd0);
    assign pipe_valid = pipe_we && (pipe_rd != 5'd0);
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign pop        = grant_ll;

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    assign pipe_stall = (starve_cnt == STARVE_LIMIT);
    assign grant_ll   = !fifo_empty && (pipe_stall || !pipe_valid);
    assign grant_pipe = pipe_valid && !pipe_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (!fifo_empty && starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // A pipe write presented during a forced bubble is lost; upstream must honour pipe_stall.
    stall_respected: assert property (@(posedge clk) disable iff (!rst_n) !(pipe_stall && pipe_we));
`else
    assign pipe_stall = 1'b0;
    assign grant_ll   = !fifo_empty && !pipe_valid;
    assign grant_pipe = pipe_valid;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ll_rd;
            fifo_data[wr_ptr] <= ll_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue applied after the grant clear so a same-cycle set of the same register wins.
    always_comb begin
        pending_next = pending;
        if (grant_ll) begin
            pending_next[head_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 5'd0) begin
            pending_next[iss_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            rd        <= 5'd0;
            WriteData <= '0;
        end else if (grant_pipe) begin
            RegWrite  <= 1'b1;
            rd        <= pipe_rd;
            WriteData <= pipe_data;
        end else if (grant_ll) begin
            RegWrite  <= 1'b1;
            rd        <= head_rd;
            WriteData <= head_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

endmodule
